// File: rtl/sclk_burst_scheduler.sv
// ============================================================================
// Module : sclk_burst_scheduler
// Brief  : Round-robin arbiter sharing one programmable sclk divider among
//          NREQ requesters; runs one burst of nbits sclk periods per grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sclk_burst_scheduler #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DIV_W-1:0]  div,
    input  logic [NREQ*CNT_W-1:0]  nbits,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   sclk,
    output logic                   sclk_rise,
    output logic [NREQ-1:0]        done
);

    localparam int c_IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state, w_state_n;
    logic [c_IDX_W-1:0]   r_ptr, w_ptr_n;
    logic [c_IDX_W-1:0]   r_g, w_g_n;
    logic [DIV_W-1:0]     r_div, w_div_n;
    logic [CNT_W-1:0]     r_nbits, w_nbits_n;
    logic [DIV_W-1:0]     r_count, w_count_n;
    logic [CNT_W-1:0]     r_periods, w_periods_n;
    logic [NREQ-1:0]      r_gnt, w_gnt_n;
    logic                 r_busy, w_busy_n;
    logic                 r_sclk, w_sclk_n;
    logic                 r_sclk_rise, w_sclk_rise_n;
    logic [NREQ-1:0]      r_done, w_done_n;

    logic [DIV_W-1:0]     w_div_arr   [NREQ];
    logic [CNT_W-1:0]     w_nbits_arr [NREQ];
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_win;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_div_arr[i]   = div[i*DIV_W +: DIV_W];
        assign w_nbits_arr[i] = nbits[i*CNT_W +: CNT_W];
    end

    function automatic logic [c_IDX_W-1:0] rr_idx(input logic [c_IDX_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NREQ) j = j - NREQ;
        return c_IDX_W'(j);
    endfunction

    // Scan downward so the candidate closest to r_ptr is assigned last and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_ptr_n       = r_ptr;
        w_g_n         = r_g;
        w_div_n       = r_div;
        w_nbits_n     = r_nbits;
        w_count_n     = r_count;
        w_periods_n   = r_periods;
        w_gnt_n       = r_gnt;
        w_busy_n      = r_busy;
        w_sclk_n      = r_sclk;
        w_sclk_rise_n = 1'b0;
        w_done_n      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_g_n     = w_win;
                    w_gnt_n   = NREQ'(1) << w_win;
                    w_busy_n  = 1'b1;
                    w_state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                w_div_n     = (w_div_arr[r_g] == '0) ? DIV_W'(1) : w_div_arr[r_g];
                w_nbits_n   = w_nbits_arr[r_g];
                w_count_n   = DIV_W'(1);
                w_periods_n = '0;
                w_sclk_n    = 1'b0;
                if (w_nbits_arr[r_g] == '0) begin
                    w_state_n = S_DONE;
                    w_done_n  = NREQ'(1) << r_g;
                end else begin
                    w_state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == r_div) begin
                    w_count_n     = DIV_W'(1);
                    w_sclk_n      = ~r_sclk;
                    w_sclk_rise_n = ~r_sclk;
                    if (r_sclk) begin
                        w_periods_n = r_periods + CNT_W'(1);
                        // Burst ends on the falling edge that completes period nbits.
                        if (r_periods + CNT_W'(1) == r_nbits) begin
                            w_state_n = S_DONE;
                            w_done_n  = NREQ'(1) << r_g;
                        end
                    end
                end else begin
                    w_count_n = r_count + DIV_W'(1);
                end
            end
            S_DONE: begin
                w_gnt_n   = '0;
                w_busy_n  = 1'b0;
                w_sclk_n  = 1'b0;
                w_ptr_n   = (r_g == c_IDX_W'(NREQ - 1)) ? '0 : r_g + c_IDX_W'(1);
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_g         <= '0;
            r_div       <= '0;
            r_nbits     <= '0;
            r_count     <= '0;
            r_periods   <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_sclk      <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_done      <= '0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_g         <= w_g_n;
            r_div       <= w_div_n;
            r_nbits     <= w_nbits_n;
            r_count     <= w_count_n;
            r_periods   <= w_periods_n;
            r_gnt       <= w_gnt_n;
            r_busy      <= w_busy_n;
            r_sclk      <= w_sclk_n;
            r_sclk_rise <= w_sclk_rise_n;
            r_done      <= w_done_n;
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign sclk      = r_sclk;
    assign sclk_rise = r_sclk_rise;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sclk_burst_scheduler.sv
// ============================================================================
// Module : tb_sclk_burst_scheduler
// Brief  : Self-checking bench for sclk_burst_scheduler (burst-timeline model).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sclk_burst_scheduler;

    localparam int NREQ  = 4;
    localparam int DIV_W = 16;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*DIV_W-1:0] div;
    logic [NREQ*CNT_W-1:0] nbits;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  sclk;
    logic                  sclk_rise;
    logic [NREQ-1:0]       done;

    sclk_burst_scheduler #(.NREQ(NREQ), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .div(div), .nbits(nbits),
        .gnt(gnt), .busy(busy), .sclk(sclk), .sclk_rise(sclk_rise), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: a granted burst is a timeline indexed by t = edges since grant.
    int m_busy = 0, m_ptr = 0, m_g = 0, m_t = 0, m_D = 1, m_N = 0, m_tdone = 1;
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_t = 0;
        end else if (m_busy == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_busy == 0 && req[(m_ptr + k) % NREQ]) begin
                    m_busy = 1; m_g = (m_ptr + k) % NREQ; m_t = 0;
                end
            end
        end else begin
            m_t++;
            if (m_t == 1) begin
                m_D = int'(div[m_g*DIV_W +: DIV_W]);
                if (m_D == 0) m_D = 1;
                m_N = int'(nbits[m_g*CNT_W +: CNT_W]);
                m_tdone = (m_N == 0) ? 1 : 1 + 2 * m_D * m_N;
            end
            if (m_t == m_tdone + 1) begin
                m_busy = 0; m_ptr = (m_g + 1) % NREQ;
            end
        end
    end

    // Burst event monitor (offsets are relative to the grant edge E0).
    int rises = 0, start_rises = 0, first_rise = -1, e0 = 0, start_cnt = 0;
    int done_cnt = 0, done_off = -1, fall_cnt = 0, fall_off = -1;
    logic [NREQ-1:0] gnt0 = '0, done_val = '0;
    logic prevb = 1'b0;
    initial forever begin
        @(negedge clk);
        if (busy && !prevb) begin
            e0 = cyc; start_rises = rises; first_rise = -1; gnt0 = gnt; start_cnt++;
        end
        if (sclk_rise) begin
            rises++;
            if (first_rise < 0) first_rise = cyc - e0;
        end
        if (done != '0) begin
            done_cnt++; done_off = cyc - e0; done_val = done;
        end
        if (!busy && prevb) begin
            fall_cnt++; fall_off = cyc - e0;
        end
        prevb = busy;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Every tick compares all DUT outputs against the model at the falling edge.
    task automatic tick();
        logic [NREQ-1:0] eg, ed;
        logic es, er;
        int ph;
        @(negedge clk);
        eg = (m_busy != 0) ? NREQ'(1) << m_g : '0;
        ed = '0; es = 1'b0; er = 1'b0;
        if (m_busy != 0 && m_t >= 1) begin
            if (m_t == m_tdone) ed = eg;
            if (m_N > 0 && m_t >= 1 + m_D && m_t < m_tdone) begin
                ph = (m_t - 1 - m_D) % (2 * m_D);
                es = (ph < m_D);
                er = (ph == 0);
            end
        end
        check("cycle", {21'd0, gnt, busy, sclk, sclk_rise, done},
                       {21'd0, eg, (m_busy != 0), es, er, ed});
        #1;
    endtask

    task automatic set_cfg(input int i, input int d, input int n);
        div[i*DIV_W +: DIV_W]   = DIV_W'(d);
        nbits[i*CNT_W +: CNT_W] = CNT_W'(n);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_burst(input logic [NREQ-1:0] mask, input int budget);
        int n, f0;
        f0 = fall_cnt; n = 0;
        req = mask;
        while (!busy && n < 20) begin tick(); n++; end
        req = '0;
        while (fall_cnt == f0 && n < budget) begin tick(); n++; end
        check("burst_timeout", 32'(fall_cnt != f0), 32'd1);
    endtask

    initial begin
        logic [NREQ-1:0] order [5];
        logic [NREQ-1:0] exp_order [5];
        int ng, sc, n, d0;

        reset = 1'b1; req = '0; div = '0; nbits = '0;
        tick();
        check("reset_outputs", {27'd0, gnt, busy, sclk, sclk_rise, done}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single requester: div=2, nbits=3
        set_cfg(0, 2, 3);
        run_burst(4'b0001, 100);
        check("single_first_rise", first_rise, 3);
        check("single_rises", rises - start_rises, 3);
        check("single_done_at", done_off, 13);
        check("single_done_bit", {28'd0, done_val}, 32'd1);
        check("single_busy_drop", fall_off, 14);
        tick();

        // Degenerate: div=0 behaves as 1; then nbits=0
        set_cfg(1, 0, 2);
        run_burst(4'b0010, 100);
        check("deg_first_rise", first_rise, 2);
        check("deg_rises", rises - start_rises, 2);
        check("deg_done_at", done_off, 5);
        check("deg_done_bit", {28'd0, done_val}, 32'd2);
        set_cfg(2, 5, 0);
        run_burst(4'b0100, 100);
        check("zero_rises", rises - start_rises, 0);
        check("zero_done_bit", {28'd0, done_val}, 32'd4);
        tick();

        // Round-robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++) set_cfg(i, 1, 1);
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        req = 4'b1111; ng = 0; sc = start_cnt; n = 0;
        while (ng < 5 && n < 200) begin
            tick(); n++;
            if (start_cnt != sc) begin
                sc = start_cnt; order[ng] = gnt0; ng++;
            end
        end
        req = '0;
        check("rr_grants_seen", ng, 5);
        for (int i = 0; i < 5; i++) check("rr_order", {28'd0, order[i]}, {28'd0, exp_order[i]});
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        tick();

        // Mid-burst asynchronous reset
        do_reset();
        set_cfg(0, 4, 5);
        req = 4'b0001;
        d0 = done_cnt;
        for (int i = 0; i < 15; i++) tick();
        req = '0;
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_async_zero", {27'd0, gnt, busy, sclk, sclk_rise, done}, 32'd0);
        tick();
        reset = 1'b0;
        check("mid_no_done", done_cnt, d0);
        set_cfg(2, 1, 1);
        run_burst(4'b0100, 100);
        check("mid_regrant", {28'd0, gnt0}, 32'd4);
        tick();

        // Request drop and config change during RUN
        set_cfg(3, 3, 2);
        req = 4'b1000; n = 0;
        sc = fall_cnt;
        while (!busy && n < 20) begin tick(); n++; end
        for (int i = 0; i < 4; i++) tick();
        req = '0;
        set_cfg(3, 7, 9);
        while (fall_cnt == sc && n < 200) begin tick(); n++; end
        check("drop_done_at", done_off, 13);
        check("drop_rises", rises - start_rises, 2);
        check("drop_done_bit", {28'd0, done_val}, 32'd8);
        tick();

        // Max burst
        set_cfg(0, 1, 255);
        run_burst(4'b0001, 1000);
        check("max_rises", rises - start_rises, 255);
        check("max_done_at", done_off, 511);
        tick();

        // Randomized traffic with input churn and rare resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 2) == 0)
                set_cfg(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 5)));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end
        req = '0;
        for (int i = 0; i < 80; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
